// File: rtl/hybrid_adder.sv
// Registered approximate adder/subtractor: OR-based lower part, exact ripple upper part.
// Define HYBRID_ADDER_EXACT_EN to build the lower part from exact full adders instead.
module hybrid_adder #(
  parameter int N1       = 16,
  parameter int N2       = 16,
  parameter bit addOrSub = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic [N1+N2-1:0]   A,
  input  logic [N1+N2-1:0]   B,
  output logic               out_valid,
  output logic [N1+N2-1:0]   sum,
  output logic               cout
);

  localparam int W = N1 + N2;

  logic [W-1:0]  bx;
  logic [N1-1:0] lo_sum;
  logic          c_lo;
  logic [N2-1:0] hi_sum;
  logic          hi_cout;

  logic [W-1:0]  sum_d, sum_q;
  logic          cout_d, cout_q;
  logic          out_valid_d, out_valid_q;

  // Subtraction inverts B; the +1 only exists through the exact lower carry-in.
  assign bx = addOrSub ? ~B : B;

  always_comb begin
`ifdef HYBRID_ADDER_EXACT_EN
    logic c_chain;
    lo_sum  = '0;
    c_chain = addOrSub;
    for (int i = 0; i < N1; i++) begin
      lo_sum[i] = A[i] ^ bx[i] ^ c_chain;
      c_chain   = (A[i] & bx[i]) | (c_chain & (A[i] ^ bx[i]));
    end
    c_lo = c_chain;
`else
    lo_sum = A[N1-1:0] | bx[N1-1:0];
    c_lo   = A[N1-1] & bx[N1-1];
`endif
  end

  always_comb begin
    logic c_hi;
    hi_sum = '0;
    c_hi   = c_lo;
    for (int j = 0; j < N2; j++) begin
      hi_sum[j] = A[N1+j] ^ bx[N1+j] ^ c_hi;
      c_hi      = (A[N1+j] & bx[N1+j]) | (c_hi & (A[N1+j] ^ bx[N1+j]));
    end
    hi_cout = c_hi;
  end

  // Output register: captures on in_valid, otherwise holds.
  always_comb begin
    sum_d       = sum_q;
    cout_d      = cout_q;
    out_valid_d = in_valid;
    if (in_valid) begin
      sum_d  = {hi_sum, lo_sum};
      cout_d = hi_cout;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q       <= '0;
      cout_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign sum       = sum_q;
  assign cout      = cout_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_hybrid_adder.sv
// Bench for hybrid_adder: an add and a subtract instance share one stimulus stream.
module tb_hybrid_adder;

`ifdef HYBRID_ADDER_EXACT_EN
  localparam bit EXACT = 1'b1;
`else
  localparam bit EXACT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] a, b;
  logic [31:0] sum_a, sum_s;
  logic        cout_a, cout_s, ov_a, ov_s;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  hybrid_adder #(.N1(16), .N2(16), .addOrSub(1'b0)) dut_add (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .A(a), .B(b),
    .out_valid(ov_a), .sum(sum_a), .cout(cout_a)
  );

  hybrid_adder #(.N1(16), .N2(16), .addOrSub(1'b1)) dut_sub (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .A(a), .B(b),
    .out_valid(ov_s), .sum(sum_s), .cout(cout_s)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [32:0] add_apx;  // {cout, sum}
    logic [32:0] add_ex;
    logic [32:0] sub_apx;
    logic [32:0] sub_ex;
  } vec_t;

  typedef struct {
    logic [32:0] add;
    logic [32:0] sub;
  } exp_t;

  vec_t vecs[6];
  exp_t sb[$];

  function automatic logic [32:0] golden(logic [31:0] x, logic [31:0] y, bit sub);
    logic [31:0] yx;
    logic [16:0] lo, hi;
    logic [15:0] los;
    logic        c;
    yx = sub ? ~y : y;
    if (EXACT) begin
      lo  = {1'b0, x[15:0]} + {1'b0, yx[15:0]} + 17'(sub);
      los = lo[15:0];
      c   = lo[16];
    end else begin
      los = x[15:0] | yx[15:0];
      c   = x[15] & yx[15];
    end
    hi = {1'b0, x[31:16]} + {1'b0, yx[31:16]} + 17'(c);
    return {hi, los};
  endfunction

  task automatic check(input string nm, input logic [33:0] act, input logic [33:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got {ov,cout,sum}=%h, expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [32:0] pick(logic [32:0] apx, logic [32:0] ex);
    return EXACT ? ex : apx;
  endfunction

  initial begin
    exp_t e;
    vecs[0] = '{32'h000000FF, 32'h00000001, {1'b0, 32'h000000FF}, {1'b0, 32'h00000100},
                {1'b0, 32'hFFFFFFFF}, {1'b1, 32'h000000FE}};
    vecs[1] = '{32'h00018000, 32'h00008000, {1'b0, 32'h00028000}, {1'b0, 32'h00020000},
                {1'b1, 32'h0000FFFF}, {1'b1, 32'h00010000}};
    vecs[2] = '{32'hFFFF0000, 32'h00010000, {1'b1, 32'h00000000}, {1'b1, 32'h00000000},
                {1'b1, 32'hFFFDFFFF}, {1'b1, 32'hFFFE0000}};
    vecs[3] = '{32'h00050000, 32'h00030000, {1'b0, 32'h00080000}, {1'b0, 32'h00080000},
                {1'b1, 32'h0001FFFF}, {1'b1, 32'h00020000}};
    vecs[4] = '{32'h00000000, 32'h00000000, {1'b0, 32'h00000000}, {1'b0, 32'h00000000},
                {1'b0, 32'hFFFFFFFF}, {1'b1, 32'h00000000}};
    vecs[5] = '{32'hFFFFFFFF, 32'hFFFFFFFF, {1'b1, 32'hFFFFFFFF}, {1'b1, 32'hFFFFFFFE},
                {1'b0, 32'hFFFFFFFF}, {1'b1, 32'h00000000}};

    rst_n = 1'b0; in_valid = 1'b1; a = 32'hDEADBEEF; b = 32'h12345678;
    #3;
    check("reset_add", {ov_a, cout_a, sum_a}, 34'h0);
    check("reset_sub", {ov_s, cout_s, sum_s}, 34'h0);
    @(posedge clk); #1;
    check("reset_held_add", {ov_a, cout_a, sum_a}, 34'h0);
    @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b0;

    // Directed vectors, back to back.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      a = vecs[i].a; b = vecs[i].b; in_valid = 1'b1;
      @(posedge clk); #1;
      check($sformatf("vec%0d_add", i), {ov_a, cout_a, sum_a}, {1'b1, pick(vecs[i].add_apx, vecs[i].add_ex)});
      check($sformatf("vec%0d_sub", i), {ov_s, cout_s, sum_s}, {1'b1, pick(vecs[i].sub_apx, vecs[i].sub_ex)});
    end

    // in_valid low: results hold, out_valid drops.
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      in_valid = 1'b0; a = $urandom; b = $urandom;
      @(posedge clk); #1;
      check($sformatf("hold%0d_add", k), {ov_a, cout_a, sum_a}, {1'b0, pick(vecs[5].add_apx, vecs[5].add_ex)});
      check($sformatf("hold%0d_sub", k), {ov_s, cout_s, sum_s}, {1'b0, pick(vecs[5].sub_apx, vecs[5].sub_ex)});
    end

    // Asynchronous reset mid-cycle while a valid result is showing.
    @(negedge clk);
    a = vecs[1].a; b = vecs[1].b; in_valid = 1'b1;
    @(posedge clk); #1;
    check("pre_rst_valid", {ov_a, cout_a, sum_a}, {1'b1, pick(vecs[1].add_apx, vecs[1].add_ex)});
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_add", {ov_a, cout_a, sum_a}, 34'h0);
    check("async_rst_sub", {ov_s, cout_s, sum_s}, 34'h0);
    @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check($sformatf("post_rst_idle%0d", k), {ov_a, cout_a, sum_a, ov_s, cout_s, sum_s} == 68'h0 ? 34'h0 : 34'h1, 34'h0);
    end
    @(negedge clk);
    a = vecs[3].a; b = vecs[3].b; in_valid = 1'b1;
    @(posedge clk); #1;
    check("first_after_rst_add", {ov_a, cout_a, sum_a}, {1'b1, pick(vecs[3].add_apx, vecs[3].add_ex)});
    check("first_after_rst_sub", {ov_s, cout_s, sum_s}, {1'b1, pick(vecs[3].sub_apx, vecs[3].sub_ex)});

    // Random back-to-back stream through the scoreboard.
    sb.delete();
    for (int i = 0; i <= 10000; i++) begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("rand_add", {ov_a, cout_a, sum_a}, {1'b1, e.add});
        check("rand_sub", {ov_s, cout_s, sum_s}, {1'b1, e.sub});
      end
      if (i < 10000) begin
        a = $urandom; b = $urandom; in_valid = 1'b1;
        e.add = golden(a, b, 1'b0);
        e.sub = golden(a, b, 1'b1);
        sb.push_back(e);
      end else begin
        in_valid = 1'b0;
      end
    end
    if (sb.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL scoreboard_drain: got %0d entries left, expected 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hybrid_adder.md
HYBRID_ADDER -- requirements
Module: hybrid_adder

Interface
REQ-001 Parameter N1, default 16: width of approximate lower part, N1 >= 1.
REQ-002 Parameter N2, default 16: width of exact upper part, N2 >= 1.
REQ-003 Parameter addOrSub, default 0: 0 = add, 1 = subtract; fixed at elaboration.
REQ-004 Port clk, input, 1: single clock; all state updates on rising edge.
REQ-005 Port rst_n, input, 1: asynchronous, active-low reset.
REQ-006 Port in_valid, input, 1: A and B are valid this cycle.
REQ-007 Port A, input, N1+N2: operand A, two's complement.
REQ-008 Port B, input, N1+N2: operand B, two's complement.
REQ-009 Port out_valid, output, 1: sum and cout hold a new result.
REQ-010 Port sum, output, N1+N2: registered approximate result.
REQ-011 Port cout, output, 1: registered carry out of the MSB.

Function
REQ-012 Effective operand: Bx = B when addOrSub = 0; Bx = bitwise NOT B when addOrSub = 1; no +1 injection anywhere.
REQ-013 Lower part, bits 0..N1-1: s[i] = A[i] OR Bx[i], lower-part OR, no carry chain.
REQ-014 Carry into upper part: c = A[N1-1] AND Bx[N1-1].
REQ-015 Upper part, bits N1..N1+N2-1: exact ripple-carry add of A_hi + Bx_hi + c.
REQ-016 {cout, sum_hi} is the (N2+1)-bit exact result of the upper add; all arithmetic is modulo 2^(N1+N2).
REQ-017 In subtract mode, cout = 1 means no borrow from the upper part.
REQ-018 Latency is 1 cycle: when in_valid = 1 at edge k, sum and cout update at edge k; out_valid = 1 after edge k.
REQ-019 When in_valid = 0 at an edge, sum and cout hold their values and out_valid = 0.
REQ-020 There is no backpressure; a new operand pair is accepted every cycle, full throughput.
REQ-021 Combinational datapath only between input and output registers; inputs are not registered.

Reset
REQ-022 While rst_n = 0: sum = 0, cout = 0, out_valid = 0, immediately and independent of clk.
REQ-023 Reset asserted mid-stream discards the in-flight result; the first edge after release with in_valid = 1 produces a valid result.

Configuration
REQ-024 Macro HYBRID_ADDER_EXACT_EN: when defined, lower bits use exact full adders with carry-in = addOrSub, and carry c into the upper part is the true lower carry-out, giving exact A+B or A-B.
REQ-025 Without HYBRID_ADDER_EXACT_EN, REQ-013/014 approximation applies; ports, latency and reset are identical in both builds.

Verification (N1 = 16, N2 = 16 unless stated)
REQ-026 Add: A = 0x000000FF, B = 0x00000001, in_valid = 1 -> next cycle sum = 0x000000FF, cout = 0, out_valid = 1 (exact build: 0x00000100).
REQ-027 Add with carry to upper part: A = 0x00018000, B = 0x00008000 -> sum = 0x00028000, cout = 0.
REQ-028 Upper overflow: A = 0xFFFF0000, B = 0x00010000 -> sum = 0x00000000, cout = 1.
REQ-029 Subtract (addOrSub = 1): A = 0x00050000, B = 0x00030000 -> sum = 0x0001FFFF, cout = 1 (exact build: 0x00020000, cout = 1).
REQ-030 Reset and hold: pulse rst_n low asynchronously mid-clock with out_valid = 1 -> sum, cout and out_valid become 0 immediately; then in_valid = 0 for 3 cycles -> outputs stay 0.
REQ-031 Random: 10k random A/B back-to-back each cycle -> each result matches a golden model of REQ-012..016 one cycle later in both macro builds.
